// File: rtl/pulse_gen.sv
// pulse_gen: timebase for the mm:ss display timer.
// Produces a free-running scan tick and a run/pause-gated count tick from
// the board clock, with a synchronised, debounced run/pause button.
// Define PG_SIM_FAST_EN to shrink all divisors for simulation
// (TICK_DIV=1000, SCAN_DIV=5, DB_CNT=4); the parameters are ignored then.
module pulse_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 200,
  parameter int DB_MS   = 10
) (
  input  logic       PG_CLK,
  input  logic       PG_RST_N,
  input  logic       PG_BTN_RUN,
  input  logic       PG_CLR,
  output logic       PG_1Hz,
  output logic       PG_200Hz,
  output logic [1:0] PG_state
);

`ifdef PG_SIM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam int TICK_DIV = FAST ? 1000 : CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = FAST ? 5    : CLK_HZ / SCAN_HZ;
  localparam int DB_CNT   = FAST ? 4    : CLK_HZ / 1000 * DB_MS;

  // A divisor of 1 still needs a one-bit counter that simply stays at 0
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DB_CNT   > 1) ? $clog2(DB_CNT)   : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DB_CNT - 1);

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            btnMeta_q, btnSync_q;
  logic            dbLevel_q, dbLevel_d;
  logic [DW-1:0]   dbCnt_q, dbCnt_d;
  logic            press_q, press_d;
  logic [SW-1:0]   scanCnt_q, scanCnt_d;
  logic            scanPulse_q, scanPulse_d;
  logic [TW-1:0]   tickCnt_q, tickCnt_d;
  logic            tickPulse_q, tickPulse_d;

  // Datapath registers: synchroniser, debounce, press pulse and both prescalers
  always_ff @(posedge PG_CLK or negedge PG_RST_N) begin
    if (!PG_RST_N) begin
      btnMeta_q   <= 1'b0;
      btnSync_q   <= 1'b0;
      dbLevel_q   <= 1'b0;
      dbCnt_q     <= '0;
      press_q     <= 1'b0;
      scanCnt_q   <= '0;
      scanPulse_q <= 1'b0;
      tickCnt_q   <= '0;
      tickPulse_q <= 1'b0;
    end else begin
      btnMeta_q   <= PG_BTN_RUN;
      btnSync_q   <= btnMeta_q;
      dbLevel_q   <= dbLevel_d;
      dbCnt_q     <= dbCnt_d;
      press_q     <= press_d;
      scanCnt_q   <= scanCnt_d;
      scanPulse_q <= scanPulse_d;
      tickCnt_q   <= tickCnt_d;
      tickPulse_q <= tickPulse_d;
    end
  end

  // Debounce: accept the synced level after DB_CNT consecutive differing cycles;
  // only an accepted rising level produces a press event
  always_comb begin
    dbLevel_d = dbLevel_q;
    dbCnt_d   = '0;
    press_d   = 1'b0;
    if (btnSync_q != dbLevel_q) begin
      if (dbCnt_q == DB_MAX) begin
        dbLevel_d = btnSync_q;
        press_d   = btnSync_q;
      end else begin
        dbCnt_d = dbCnt_q + DW'(1);
      end
    end
  end

  // Scan prescaler: free-running in every state, unaffected by clear
  always_comb begin
    scanPulse_d = 1'b0;
    if (scanCnt_q == SCAN_MAX) begin
      scanCnt_d   = '0;
      scanPulse_d = 1'b1;
    end else begin
      scanCnt_d = scanCnt_q + SW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge PG_CLK or negedge PG_RST_N) begin
    if (!PG_RST_N) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and tick prescaler: clear wins over a press, the prescaler
  // only advances while RUNNING so a pause on the wrap edge still pulses
  always_comb begin
    state_d     = state_q;
    tickCnt_d   = tickCnt_q;
    tickPulse_d = 1'b0;
    if (PG_CLR) begin
      state_d   = STOPPED;
      tickCnt_d = '0;
    end else begin
      if (state_q == RUNNING) begin
        if (tickCnt_q == TICK_MAX) begin
          tickCnt_d   = '0;
          tickPulse_d = 1'b1;
        end else begin
          tickCnt_d = tickCnt_q + TW'(1);
        end
      end
      if (press_q) begin
        case (state_q)
          STOPPED: state_d = RUNNING;
          RUNNING: state_d = PAUSED;
          PAUSED:  state_d = RUNNING;
          default: state_d = STOPPED;
        endcase
      end
    end
  end

  assign PG_1Hz   = tickPulse_q;
  assign PG_200Hz = scanPulse_q;
  assign PG_state = state_q;

endmodule
